// File: rtl/punc_mem_arbiter.sv
// Single-port PUnC memory arbiter: core has priority, a starvation counter forces debug progress,
// and a debug lock gives the debug port exclusive ownership while the core is halted.
module punc_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a requester raises req with we/addr/wdata and holds them stable until it
  // samples gnt=1 at a rising clk edge; that edge completes exactly one access. Read data
  // returns one cycle later, flagged by the requester's rvalid.

  localparam int          CNT_W      = 4;
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } rd_owner_e;

  lock_state_e       lock_state, lock_state_nxt;
  rd_owner_e         rd_owner, rd_owner_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;

  // Arbitration; everything is gated off while rst is high.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!rst) begin
      if (lock_state == LOCKED) begin
        dbg_gnt = dbg_req;
      end else if (dbg_req && (wait_cnt == MAX_WAIT_C)) begin
        dbg_gnt = 1'b1;
      end else if (core_req) begin
        core_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  assign core_stall = core_req && !core_gnt;
  assign dbg_locked = (lock_state == LOCKED);

  always_comb begin
    mem_en    = core_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Lock FSM: entered only through a granted debug access, left only when dbg_lock drops.
  always_comb begin
    lock_state_nxt = lock_state;
    case (lock_state)
      UNLOCKED: if (dbg_gnt && dbg_lock) lock_state_nxt = LOCKED;
      LOCKED:   if (!dbg_lock)           lock_state_nxt = UNLOCKED;
      default:                           lock_state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) lock_state <= UNLOCKED;
    else     lock_state <= lock_state_nxt;
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!dbg_req || dbg_gnt) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt < MAX_WAIT_C) begin
      wait_cnt_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= '0;
    else     wait_cnt <= wait_cnt_nxt;
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (core_gnt && !core_we)     rd_owner_nxt = OWN_CORE;
    else if (dbg_gnt && !dbg_we)  rd_owner_nxt = OWN_DBG;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_owner <= OWN_NONE;
    else     rd_owner <= rd_owner_nxt;
  end

  // A read in flight when rst rises is dropped rather than delivered.
  assign core_rvalid = !rst && (rd_owner == OWN_CORE);
  assign dbg_rvalid  = !rst && (rd_owner == OWN_DBG);

  assign core_rdata = core_rvalid ? mem_rdata : core_rdata_q;
  assign dbg_rdata  = dbg_rvalid  ? mem_rdata : dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      if (core_rvalid) core_rdata_q <= mem_rdata;
      if (dbg_rvalid)  dbg_rdata_q  <= mem_rdata;
    end
  end

endmodule

// File: doc/punc_mem_arbiter.md
Name: punc_mem_arbiter

Overview:
Shares the single-port PUnC main memory between the core (fetch, LD/LDR/LDI, ST/STR/STI) and a debug/DMA port.
Each cycle it picks at most one requester, drives the memory port, and routes the 1-cycle-latency read data back to the requester that issued the read.
The core has priority. A starvation counter guarantees debug progress.
core_stall tells the PUnC control FSM to hold its current state.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MAX_WAIT, 4, consecutive denied debug-request cycles before debug overrides core priority (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
core_req  in  1  core access request
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core access issued this cycle
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_W  core read data
core_stall  out  1  core_req && !core_gnt
dbg_req  in  1  debug access request
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_lock  in  1  debug requests exclusive ownership (core halted)
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
dbg_locked  out  1  lock currently held
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read is issued

Behaviour:
- Reset (rst=1 at posedge):
  - wait_cnt=0, rd_owner=NONE, lock FSM=UNLOCKED.
  - While rst is high, gnt/mem_en/mem_we are forced 0 combinationally.
  - After reset: rvalid=0, stall follows req.
- Grant is combinational, same cycle. A requester holds req/we/addr/wdata stable until it sees gnt high at a clock edge. One access per gnt cycle.
- Lock FSM states:
  - UNLOCKED: dbg_gnt && dbg_lock -> LOCKED.
  - LOCKED: !dbg_lock -> UNLOCKED. While LOCKED, core_gnt=0 and dbg_locked=1.
  - Lock only releases on dbg_lock deassert, even when dbg_req=0.
- Arbitration when UNLOCKED:
  - If dbg_req && wait_cnt==MAX_WAIT: debug wins.
  - Else if core_req: core wins.
  - Else if dbg_req: debug wins.
  - Else idle.
- Exactly one of core_gnt/dbg_gnt is high when mem_en=1. mem_en = core_gnt | dbg_gnt. mem_we/addr/wdata are muxed from the winner; when idle they drive 0.
- wait_cnt:
  - +1 (saturating at MAX_WAIT) when dbg_req && !dbg_gnt.
  - Cleared on dbg_gnt or !dbg_req.
- Read return:
  - rd_owner register records the granted requester on a read grant; otherwise NONE.
  - Next cycle, rvalid is asserted for the owner only; its rdata = mem_rdata.
  - The non-owner's rdata is held at its last value (reset 0).
- Writes produce no rvalid.
- Back-to-back grants are legal every cycle. A read return and a new grant may coincide.
- Reset mid-read: the pending rvalid is dropped (rd_owner->NONE).
- Worst-case core wait when unlocked: 1 cycle per MAX_WAIT+1 cycles. Worst-case debug wait: MAX_WAIT cycles.

Test Plan:
1. Core-only read: core_req=1, core_we=0, addr=0x3000 with mem[0x3000]=0x1234.
   -> core_gnt same cycle, mem_en=1; next cycle core_rvalid=1, core_rdata=0x1234; core_stall=0.
2. Simultaneous first requests: core reads, debug writes 0xBEEF to 0x4000.
   -> core granted; debug waits. Debug is granted once the core drops its request, and mem[0x4000]=0xBEEF afterwards.
3. Starvation: core_req held high continuously, dbg_req=1 from cycle 0, MAX_WAIT=4.
   -> dbg_gnt in cycle 4, core_stall=1 in that cycle only, wait_cnt returns to 0.
4. Lock: debug granted with dbg_lock=1, then 3 debug reads while core_req=1.
   -> core_gnt=0, dbg_locked=1 throughout. After dbg_lock falls, core is granted the next cycle.
5. Interleaved read returns: core read (0x0010->0xAAAA) in cycle N, debug read (0x0020->0x5555) in cycle N+1.
   -> core_rvalid only in N+1, dbg_rvalid only in N+2, with the correct data routing.
6. Reset mid-read: assert rst in the cycle after a core read grant.
   -> no core_rvalid afterwards; all gnt=0 while rst=1; normal core grant resumes after release.
